// File: rtl/bsd_pkg.sv
// Shared types for the binary <-> radix-4 binary-signed-digit converters.
package bsd_pkg;

  localparam int unsigned DIGITS_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Booth window {b[2i+1], b[2i], b[2i-1]}
  typedef logic [2:0] window_t;

  typedef struct packed {
    logic sign;
    logic m1;
    logic m0;
  } digit_t;

endpackage

// File: rtl/bsd_digit_enc.sv
// Radix-4 Booth recoder: one 3-bit window to a {sign, m1, m0} digit code.
module bsd_digit_enc
  import bsd_pkg::*;
(
  input  window_t window,
  output digit_t  code_c
);

  // Value = -2*w[2] + w[1] + w[0]; zero is always +0
  always_comb begin
    code_c = '0;
    case (window)
      3'b001, 3'b010: code_c.m0 = 1'b1;
      3'b011:         code_c.m1 = 1'b1;
      3'b100: begin
        code_c.sign = 1'b1;
        code_c.m1   = 1'b1;
      end
      3'b101, 3'b110: begin
        code_c.sign = 1'b1;
        code_c.m0   = 1'b1;
      end
      default: code_c = '0;
    endcase
  end

endmodule

// File: rtl/bin_2_bsd.sv
// Sequential two's-complement to radix-4 BSD encoder, one Booth digit per clock.
module bin_2_bsd
  import bsd_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DIGITS-1:0]   bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS-1:0]     bsd_2,
  output logic [DIGITS-1:0]     bsd_1,
  output logic [DIGITS-1:0]     bsd_0
);

  localparam int unsigned W     = 2 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t           state;
  state_t           state_next;
  logic [W:0]       sh;
  logic [CNT_W-1:0] cnt;
  digit_t           code_c;

  bsd_digit_enc u_enc (
    .window (sh[2:0]),
    .code_c (code_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CONV;
      CONV:    if (cnt == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift register carries b[-1]=0 in bit 0; window is always sh[2:0]
  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      cnt       <= '0;
      bsd_2     <= '0;
      bsd_1     <= '0;
      bsd_0     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= {bin, 1'b0};
            cnt   <= '0;
            bsd_2 <= '0;
            bsd_1 <= '0;
            bsd_0 <= '0;
          end
        end
        CONV: begin
          bsd_2[cnt] <= code_c.sign;
          bsd_1[cnt] <= code_c.m1;
          bsd_0[cnt] <= code_c.m0;
          sh         <= {{2{sh[W]}}, sh[W:2]};
          if (cnt != LAST) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
